// File: rtl/ddr_burst_port.sv
// Bridges data-cache read/store/jump-address requests onto single DDR read or write bursts.
// One request is served at a time; the served request must drop before the next one is accepted.
module ddr_burst_port #(
    parameter int DATA_CACHE_DEPTH = 16,
    parameter int DATA_WIDTH       = 16,
    parameter int DDR_ADDR_WIDTH   = 28,
    parameter int JMP_WORDS        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      DATA_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
    input  logic                      DATA_store_req,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
    input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
    input  logic                      JMP_ADDR_read_req,
    output logic [DATA_WIDTH-1:0]     DATA_to_cache,
    output logic                      rd_burst_data_valid,
    output logic [9:0]                rd_cnt_data,
    output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
    output logic                      jmp_addr_valid,
    output logic                      wr_data_ack,
    output logic                      ddr_rd_req,
    output logic [9:0]                ddr_rd_len,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    input  logic [DATA_WIDTH-1:0]     ddr_rd_data,
    input  logic                      ddr_rd_data_valid,
    input  logic                      ddr_rd_finish,
    output logic                      ddr_wr_req,
    output logic [9:0]                ddr_wr_len,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr,
    input  logic                      ddr_wr_data_req,
    output logic [DATA_WIDTH-1:0]     ddr_wr_data,
    input  logic                      ddr_wr_finish
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_JRD, S_DONE} state_t;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_JRD} op_t;

    localparam logic [9:0]  DATA_LEN  = 10'(DATA_CACHE_DEPTH);
    localparam logic [9:0]  JMP_LEN   = 10'(JMP_WORDS);
    localparam logic [10:0] DATA_LIM  = 11'(DATA_CACHE_DEPTH);
    localparam logic [10:0] JMP_LIM   = 11'(JMP_WORDS);

    state_t                    state_q, state_d;
    op_t                       op_q, op_d;
    logic [10:0]               word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0]     data_to_cache_q, data_to_cache_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [9:0]                rd_cnt_q, rd_cnt_d;
    logic [DDR_ADDR_WIDTH-1:0] jmp_addr_q, jmp_addr_d;
    logic                      jmp_valid_q, jmp_valid_d;
    logic                      ddr_rd_req_q, ddr_rd_req_d;
    logic [9:0]                ddr_rd_len_q, ddr_rd_len_d;
    logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr_q, ddr_rd_addr_d;
    logic                      ddr_wr_req_q, ddr_wr_req_d;
    logic [9:0]                ddr_wr_len_q, ddr_wr_len_d;
    logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr_q, ddr_wr_addr_d;

    // Jump words land at k*DATA_WIDTH; anything shifted past the address width falls off.
    logic [DDR_ADDR_WIDTH-1:0] jmp_word_ext;
    logic [DDR_ADDR_WIDTH-1:0] jmp_word_mask;
    logic                      served_req;

    assign jmp_word_ext  = DDR_ADDR_WIDTH'(ddr_rd_data);
    assign jmp_word_mask = DDR_ADDR_WIDTH'({DATA_WIDTH{1'b1}});

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case can infer a latch.
        state_d         = state_q;
        op_d            = op_q;
        word_cnt_d      = word_cnt_q;
        data_to_cache_d = data_to_cache_q;
        rd_valid_d      = 1'b0;
        rd_cnt_d        = rd_cnt_q;
        jmp_addr_d      = jmp_addr_q;
        jmp_valid_d     = jmp_valid_q;
        ddr_rd_req_d    = ddr_rd_req_q;
        ddr_rd_len_d    = ddr_rd_len_q;
        ddr_rd_addr_d   = ddr_rd_addr_q;
        ddr_wr_req_d    = ddr_wr_req_q;
        ddr_wr_len_d    = ddr_wr_len_q;
        ddr_wr_addr_d   = ddr_wr_addr_q;

        unique case (op_q)
            OP_WR:   served_req = DATA_store_req;
            OP_RD:   served_req = DATA_read_req;
            default: served_req = JMP_ADDR_read_req;
        endcase

        unique case (state_q)
            S_IDLE: begin
                word_cnt_d = '0;
                rd_cnt_d   = '0;
                if (DATA_store_req) begin
                    state_d       = S_WR;
                    op_d          = OP_WR;
                    ddr_wr_req_d  = 1'b1;
                    ddr_wr_len_d  = DATA_LEN;
                    ddr_wr_addr_d = DATA_write_addr;
                end else if (DATA_read_req || JMP_ADDR_read_req) begin
                    state_d       = DATA_read_req ? S_RD : S_JRD;
                    op_d          = DATA_read_req ? OP_RD : OP_JRD;
                    ddr_rd_req_d  = 1'b1;
                    ddr_rd_len_d  = DATA_read_req ? DATA_LEN : JMP_LEN;
                    ddr_rd_addr_d = DATA_read_addr;
                end
            end
            S_WR: begin
                if (ddr_wr_data_req) ddr_wr_req_d = 1'b0;
                if (ddr_wr_finish) begin
                    ddr_wr_req_d = 1'b0;
                    state_d      = S_DONE;
                end
            end
            S_RD: begin
                if (ddr_rd_data_valid) begin
                    ddr_rd_req_d = 1'b0;
                    if (word_cnt_q < DATA_LIM) begin
                        data_to_cache_d = ddr_rd_data;
                        rd_valid_d      = 1'b1;
                        rd_cnt_d        = word_cnt_q[9:0];
                        word_cnt_d      = word_cnt_q + 11'd1;
                    end
                end
                if (ddr_rd_finish) begin
                    ddr_rd_req_d = 1'b0;
                    state_d      = S_DONE;
                end
            end
            S_JRD: begin
                if (ddr_rd_data_valid) begin
                    ddr_rd_req_d = 1'b0;
                    if (word_cnt_q < JMP_LIM) begin
                        jmp_addr_d = (jmp_addr_q & ~(jmp_word_mask << (int'(word_cnt_q) * DATA_WIDTH)))
                                   | (jmp_word_ext << (int'(word_cnt_q) * DATA_WIDTH));
                        word_cnt_d = word_cnt_q + 11'd1;
                    end
                end
                if (ddr_rd_finish) begin
                    ddr_rd_req_d = 1'b0;
                    jmp_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                // Holding here until the served request drops keeps a level request from retriggering.
                if (!served_req) begin
                    jmp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            op_q            <= OP_WR;
            word_cnt_q      <= '0;
            data_to_cache_q <= '0;
            rd_valid_q      <= 1'b0;
            rd_cnt_q        <= '0;
            jmp_addr_q      <= '0;
            jmp_valid_q     <= 1'b0;
            ddr_rd_req_q    <= 1'b0;
            ddr_rd_len_q    <= '0;
            ddr_rd_addr_q   <= '0;
            ddr_wr_req_q    <= 1'b0;
            ddr_wr_len_q    <= '0;
            ddr_wr_addr_q   <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
            state_q         <= state_d;
            op_q            <= op_d;
            word_cnt_q      <= word_cnt_d;
            data_to_cache_q <= data_to_cache_d;
            rd_valid_q      <= rd_valid_d;
            rd_cnt_q        <= rd_cnt_d;
            jmp_addr_q      <= jmp_addr_d;
            jmp_valid_q     <= jmp_valid_d;
            ddr_rd_req_q    <= ddr_rd_req_d;
            ddr_rd_len_q    <= ddr_rd_len_d;
            ddr_rd_addr_q   <= ddr_rd_addr_d;
            ddr_wr_req_q    <= ddr_wr_req_d;
            ddr_wr_len_q    <= ddr_wr_len_d;
            ddr_wr_addr_q   <= ddr_wr_addr_d;
        end
    end

    assign DATA_to_cache       = data_to_cache_q;
    assign rd_burst_data_valid = rd_valid_q;
    assign rd_cnt_data         = rd_cnt_q;
    assign JMP_ADDR_to_cache   = jmp_addr_q;
    assign jmp_addr_valid      = jmp_valid_q;
    assign ddr_rd_req          = ddr_rd_req_q;
    assign ddr_rd_len          = ddr_rd_len_q;
    assign ddr_rd_addr         = ddr_rd_addr_q;
    assign ddr_wr_req          = ddr_wr_req_q;
    assign ddr_wr_len          = ddr_wr_len_q;
    assign ddr_wr_addr         = ddr_wr_addr_q;
    assign ddr_wr_data         = DATA_to_ddr;
    assign wr_data_ack         = (state_q == S_WR) && ddr_wr_data_req;

endmodule

// File: tb/tb_ddr_burst_port.sv
// Randomized bench for ddr_burst_port: a cache/DDR driver pushes expected read words and
// jump addresses into queues; an independent monitor pops and compares as the DUT presents them.
module tb_ddr_burst_port;

    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int DAW   = 28;
    localparam int JW    = 2;

    logic           clk;
    logic           rst;
    logic           DATA_read_req;
    logic [DAW-1:0] DATA_read_addr;
    logic           DATA_store_req;
    logic [DAW-1:0] DATA_write_addr;
    logic [DW-1:0]  DATA_to_ddr;
    logic           JMP_ADDR_read_req;
    logic [DW-1:0]  DATA_to_cache;
    logic           rd_burst_data_valid;
    logic [9:0]     rd_cnt_data;
    logic [DAW-1:0] JMP_ADDR_to_cache;
    logic           jmp_addr_valid;
    logic           wr_data_ack;
    logic           ddr_rd_req;
    logic [9:0]     ddr_rd_len;
    logic [DAW-1:0] ddr_rd_addr;
    logic [DW-1:0]  ddr_rd_data;
    logic           ddr_rd_data_valid;
    logic           ddr_rd_finish;
    logic           ddr_wr_req;
    logic [9:0]     ddr_wr_len;
    logic [DAW-1:0] ddr_wr_addr;
    logic           ddr_wr_data_req;
    logic [DW-1:0]  ddr_wr_data;
    logic           ddr_wr_finish;

    ddr_burst_port #(
        .DATA_CACHE_DEPTH(DEPTH), .DATA_WIDTH(DW), .DDR_ADDR_WIDTH(DAW), .JMP_WORDS(JW)
    ) dut (
        .clk(clk), .rst(rst),
        .DATA_read_req(DATA_read_req), .DATA_read_addr(DATA_read_addr),
        .DATA_store_req(DATA_store_req), .DATA_write_addr(DATA_write_addr),
        .DATA_to_ddr(DATA_to_ddr), .JMP_ADDR_read_req(JMP_ADDR_read_req),
        .DATA_to_cache(DATA_to_cache), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_cnt_data(rd_cnt_data), .JMP_ADDR_to_cache(JMP_ADDR_to_cache),
        .jmp_addr_valid(jmp_addr_valid), .wr_data_ack(wr_data_ack),
        .ddr_rd_req(ddr_rd_req), .ddr_rd_len(ddr_rd_len), .ddr_rd_addr(ddr_rd_addr),
        .ddr_rd_data(ddr_rd_data), .ddr_rd_data_valid(ddr_rd_data_valid),
        .ddr_rd_finish(ddr_rd_finish),
        .ddr_wr_req(ddr_wr_req), .ddr_wr_len(ddr_wr_len), .ddr_wr_addr(ddr_wr_addr),
        .ddr_wr_data_req(ddr_wr_data_req), .ddr_wr_data(ddr_wr_data),
        .ddr_wr_finish(ddr_wr_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            idx;
    } rd_exp_t;

    rd_exp_t        rd_q[$];
    logic [DAW-1:0] jmp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: consumes expectations only when the DUT presents a read word or a new jump address.
    initial begin : monitor
        rd_exp_t e;
        logic    jv_prev;
        jv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_burst_data_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got word 0x%0h idx %0d, expected no word",
                             DATA_to_cache, rd_cnt_data);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_data", 32'(DATA_to_cache), 32'(e.data));
                    check("rd_cnt", 32'(rd_cnt_data), 32'(e.idx));
                end
            end
            if (jmp_addr_valid === 1'b1 && !jv_prev) begin
                if (jmp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL jmp_unexpected: got 0x%0h, expected no jump address", JMP_ADDR_to_cache);
                end else begin
                    check("jmp_addr", 32'(JMP_ADDR_to_cache), 32'(jmp_q.pop_front()));
                end
            end
            jv_prev = jmp_addr_valid;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ddr_rd_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_wr_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ddr_wr_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data_to_cache"}, 32'(DATA_to_cache), 0);
        check({tag, "_rd_valid"}, 32'(rd_burst_data_valid), 0);
        check({tag, "_rd_cnt"}, 32'(rd_cnt_data), 0);
        check({tag, "_jmp_addr"}, 32'(JMP_ADDR_to_cache), 0);
        check({tag, "_jmp_valid"}, 32'(jmp_addr_valid), 0);
        check({tag, "_ddr_rd_req"}, 32'(ddr_rd_req), 0);
        check({tag, "_ddr_rd_len"}, 32'(ddr_rd_len), 0);
        check({tag, "_ddr_rd_addr"}, 32'(ddr_rd_addr), 0);
        check({tag, "_ddr_wr_req"}, 32'(ddr_wr_req), 0);
        check({tag, "_ddr_wr_len"}, 32'(ddr_wr_len), 0);
        check({tag, "_ddr_wr_addr"}, 32'(ddr_wr_addr), 0);
    endtask

    // Services a write burst already requested by the cache, then withdraws the request.
    task automatic serve_write(input logic [DAW-1:0] addr);
        wait_wr_req("wr_req_rise");
        check("wr_addr", 32'(ddr_wr_addr), 32'(addr));
        check("wr_len", 32'(ddr_wr_len), DEPTH);
        check("wr_not_rd", 32'(ddr_rd_req), 0);
        for (int i = 0; i < DEPTH; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("wr_ack_idle", 32'(wr_data_ack), 0);
            end
            ddr_wr_data_req = 1'b1;
            DATA_to_ddr     = DW'($urandom);
            #1;
            check("wr_ack", 32'(wr_data_ack), 1);
            check("wr_data_pass", 32'(ddr_wr_data), 32'(DATA_to_ddr));
            tick();
            ddr_wr_data_req = 1'b0;
            if (i == 0) check("wr_req_drop", 32'(ddr_wr_req), 0);
        end
        ddr_wr_finish = 1'b1;
        tick();
        ddr_wr_finish = 1'b0;
        repeat (3) begin
            tick();
            check("wr_level_hold", 32'(ddr_wr_req), 0);
        end
        DATA_store_req = 1'b0;
        tick();
    endtask

    task automatic serve_read(input logic [DAW-1:0] addr, input int extra, input bit directed);
        wait_rd_req("rd_req_rise");
        check("rd_addr", 32'(ddr_rd_addr), 32'(addr));
        check("rd_len", 32'(ddr_rd_len), DEPTH);
        check("rd_not_wr", 32'(ddr_wr_req), 0);
        for (int i = 0; i < DEPTH + extra; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = directed ? DW'(32'hA000 + i) : DW'($urandom);
            if (i < DEPTH) rd_q.push_back('{data: ddr_rd_data, idx: i});
            tick();
            ddr_rd_data_valid = 1'b0;
            if (i == 0) check("rd_req_drop", 32'(ddr_rd_req), 0);
        end
        ddr_rd_finish = 1'b1;
        tick();
        ddr_rd_finish = 1'b0;
        repeat (4) begin
            tick();
            check("rd_level_hold", 32'(ddr_rd_req), 0);
        end
        check("rd_words_delivered", 32'(rd_q.size()), 0);
        DATA_read_req = 1'b0;
        tick();
    endtask

    task automatic serve_jump(input logic [DAW-1:0] addr, input logic [DW-1:0] w0,
                              input logic [DW-1:0] w1, input int extra);
        logic [63:0] full = '0;
        logic [DW-1:0] w;
        wait_rd_req("jrd_req_rise");
        check("jrd_addr", 32'(ddr_rd_addr), 32'(addr));
        check("jrd_len", 32'(ddr_rd_len), JW);
        for (int i = 0; i < JW + extra; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            w = (i == 0) ? w0 : (i == 1) ? w1 : DW'($urandom);
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = w;
            if (i < JW) full = full | (64'(w) << (i * DW));
            tick();
            ddr_rd_data_valid = 1'b0;
        end
        jmp_q.push_back(full[DAW-1:0]);
        ddr_rd_finish = 1'b1;
        tick();
        ddr_rd_finish = 1'b0;
        repeat (3) begin
            tick();
            check("jmp_valid_level", 32'(jmp_addr_valid), 1);
            check("jrd_level_hold", 32'(ddr_rd_req), 0);
        end
        check("jmp_words_delivered", 32'(jmp_q.size()), 0);
        JMP_ADDR_read_req = 1'b0;
        tick();
        check("jmp_valid_drop", 32'(jmp_addr_valid), 0);
        check("jmp_addr_held", 32'(JMP_ADDR_to_cache), 32'(full[DAW-1:0]));
    endtask

    initial begin : driver
        logic [2:0]     m;
        logic [DAW-1:0] wa;
        logic [DAW-1:0] ra;

        rst = 1'b1;
        DATA_read_req = 1'b0;  DATA_read_addr = '0;
        DATA_store_req = 1'b0; DATA_write_addr = '0;
        DATA_to_ddr = '0;      JMP_ADDR_read_req = 1'b0;
        ddr_rd_data = '0;      ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b0;
        ddr_wr_data_req = 1'b0; ddr_wr_finish = 1'b0;
        repeat (3) tick();
        check_reset("por");
        rst = 1'b0;
        tick();

        // Directed write, read and jump.
        DATA_write_addr = 28'h0005000;
        DATA_store_req  = 1'b1;
        serve_write(28'h0005000);

        DATA_read_addr = 28'h0000100;
        DATA_read_req  = 1'b1;
        serve_read(28'h0000100, 0, 1'b1);

        DATA_read_addr    = 28'h00ABCDE;
        JMP_ADDR_read_req = 1'b1;
        serve_jump(28'h00ABCDE, 16'h5678, 16'h0123, 0);

        // All three requested together: write, then read, then jump.
        DATA_write_addr   = 28'h0000123;
        DATA_read_addr    = 28'h0FEDCBA;
        DATA_store_req    = 1'b1;
        DATA_read_req     = 1'b1;
        JMP_ADDR_read_req = 1'b1;
        serve_write(28'h0000123);
        serve_read(28'h0FEDCBA, 0, 1'b0);
        serve_jump(28'h0FEDCBA, DW'($urandom), DW'($urandom), 0);

        // Overrun: surplus words must be ignored.
        DATA_read_addr = 28'h0000400;
        DATA_read_req  = 1'b1;
        serve_read(28'h0000400, 3, 1'b0);
        JMP_ADDR_read_req = 1'b1;
        serve_jump(28'h0000400, DW'($urandom), DW'($urandom), 2);

        // Reset in the middle of a read burst, then a fresh burst.
        DATA_read_addr = 28'h0000333;
        DATA_read_req  = 1'b1;
        wait_rd_req("pre_rst_rd_req_rise");
        for (int i = 0; i < 3; i++) begin
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = DW'($urandom);
            rd_q.push_back('{data: ddr_rd_data, idx: i});
            tick();
            ddr_rd_data_valid = 1'b0;
        end
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        check_reset("mid_rd");
        check("pre_rst_words", 32'(rd_q.size()), 0);
        rst = 1'b0;
        serve_read(28'h0000333, 0, 1'b0);

        // Random request mixes served in priority order.
        for (int t = 0; t < 10; t++) begin
            m  = 3'($urandom_range(1, 7));
            wa = DAW'($urandom);
            ra = DAW'($urandom);
            DATA_write_addr   = wa;
            DATA_read_addr    = ra;
            DATA_store_req    = m[0];
            DATA_read_req     = m[1];
            JMP_ADDR_read_req = m[2];
            if (m[0]) serve_write(wa);
            if (m[1]) serve_read(ra, int'($urandom_range(0, 2)), 1'b0);
            if (m[2]) serve_jump(ra, DW'($urandom), DW'($urandom), int'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        check("rd_queue_empty", 32'(rd_q.size()), 0);
        check("jmp_queue_empty", 32'(jmp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
